reg_file_param: RTL and testbench
=================================

REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 The block SHALL have parameter DW, default 32, meaning data width of each entry (8..64).
REQ-002 The block SHALL have parameter AW, default 5, meaning address width; depth = 2**AW entries (2..8).
REQ-003 The block SHALL have parameter NRP, default 2, meaning number of read ports (1..4).
REQ-004 The block SHALL have parameter ZERO_R0, default 1, meaning entry 0 is hardwired to zero when 1.
REQ-005 The block SHALL have port clock, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit, reset; it is synchronous and active-low.
REQ-007 The block SHALL have port data, input, DW bits, write data.
REQ-008 The block SHALL have port wraddress, input, AW bits, write address.
REQ-009 The block SHALL have port wren, input, 1 bit, write request.
REQ-010 The block SHALL have port rdaddress, input, NRP*AW bits, read addresses; port k uses bits [k*AW +: AW].
REQ-011 The block SHALL have port rd_clk_cls, input, 1 bit, read-address hold; 1 freezes all captured read addresses.
REQ-012 The block SHALL have port q, output, NRP*DW bits, read data; port k drives bits [k*DW +: DW].
REQ-013 The block SHALL have port busy, output, 1 bit, high while the clear sequencer runs.

Function
REQ-014 The block SHALL register data, wraddress and wren every cycle into a write stage (w_data, w_addr, w_en), independent of rd_clk_cls.
REQ-015 The block SHALL update entry w_addr with w_data on the edge after capture when w_en=1, giving a write latency of 2 edges from request to array.
REQ-016 The block SHALL capture each read address into a read stage register on every edge where rd_clk_cls=0, and SHALL hold it where rd_clk_cls=1.
REQ-017 Each q port SHALL be combinational from its captured address, with priority: (a) zero if ZERO_R0=1 and address=0; (b) w_data if w_en=1 and w_addr equals the address; (c) otherwise the array entry.
REQ-018 Writes to entry 0 SHALL be discarded when ZERO_R0=1, and the bypass of REQ-017(b) SHALL never apply to entry 0 in that case.
REQ-019 Reading therefore SHALL return data one edge after the address is presented, including data written in the immediately preceding cycle (via bypass).
REQ-020 The clear sequencer SHALL use states CLR and RUN: CLR writes zero to entry cnt then increments cnt; after writing entry 2**AW-1 it moves to RUN; RUN is terminal until reset.
REQ-021 cnt SHALL be AW+1 bits wide so that the last entry is detected without wrap-around aliasing to entry 0.
REQ-022 busy SHALL equal 1 in CLR and 0 in RUN; the clear takes exactly 2**AW cycles after rst_n rises.
REQ-023 While busy=1 the block SHALL ignore wren (w_en forced to 0), and all q ports SHALL read zero.
REQ-024 A write stage holding w_en=1 SHALL never coincide with a clear write, because w_en is forced to 0 during CLR.
REQ-025 Multiple read ports addressing the same entry SHALL all return the same value in the same cycle.

Reset
REQ-026 While rst_n=0 at an edge, the block SHALL set state=CLR, cnt=0, w_en=0, w_addr=0, w_data=0 and all read-stage addresses to 0; rst_n overrides rd_clk_cls.
REQ-027 Immediately after reset, busy SHALL be 1 and every q SHALL be 0.
REQ-028 Reset asserted mid-clear or in RUN SHALL restart the clear from entry 0 on the next edge with rst_n=1.
REQ-029 Array contents SHALL NOT be reset directly; only the sequencer zeroes them.

Verification
REQ-030 Default params: release rst_n, hold wren=1 -> busy=1 for exactly 32 cycles, no writes land, then reads of entries 0..31 all return 0.
REQ-031 After clear: write 0xDEADBEEF to r5, present rdaddress port0=5 in the next cycle -> q port0=0xDEADBEEF via bypass, and still 0xDEADBEEF two cycles later from the array.
REQ-032 Write 0x12345678 to r0 with ZERO_R0=1 -> q reads 0 on all ports, both in the bypass cycle and afterwards.
REQ-033 Capture rdaddress=7, assert rd_clk_cls=1, change rdaddress to 9 for 3 cycles -> q keeps tracking r7, including an intervening write of 0xA5A5A5A5 to r7.
REQ-034 Assert rst_n=0 for 1 cycle at clear step 10 -> busy remains 1 for a full 32 further cycles from release.
REQ-035 DW=16, AW=3, NRP=4: write distinct values to r1..r7, read with four ports at addresses 1,1,6,0 -> outputs r1,r1,r6,0; busy time after reset is 8 cycles.

Source files
------------

// File: rtl/reg_file_param.sv
// Parameterised multi-port register file with a registered write stage, write-to-read
// bypass, held read addresses and a sequencer that zeroes the array after every reset.
module reg_file_param #(
    parameter int DW      = 32,
    parameter int AW      = 5,
    parameter int NRP     = 2,
    parameter int ZERO_R0 = 1
) (
    input  logic                clock,
    input  logic                rst_n,
    input  logic [DW-1:0]       data,
    input  logic [AW-1:0]       wraddress,
    input  logic                wren,
    input  logic [NRP*AW-1:0]   rdaddress,
    input  logic                rd_clk_cls,
    output logic [NRP*DW-1:0]   q,
    output logic                busy
);
    localparam int DEPTH = 2**AW;
    // One bit wider than the address so the final entry is seen before any wrap to 0.
    localparam logic [AW:0] LAST = {1'b0, {AW{1'b1}}};
    localparam logic [AW:0] ONE  = {{AW{1'b0}}, 1'b1};

    typedef enum logic {CLR, RUN} state_t;

    state_t          state;
    logic [AW:0]     cnt;
    logic [DW-1:0]   w_data;
    logic [AW-1:0]   w_addr;
    logic            w_en;
    logic [AW-1:0]   r_addr [NRP];
    logic [DW-1:0]   mem    [DEPTH];

    // Clear sequencer: walks every entry once after reset, then parks in RUN.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state <= CLR;
            cnt   <= '0;
            busy  <= 1'b1;
        end else if (state == CLR) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            cnt <= cnt + ONE;
            if (cnt == LAST) begin
                state <= RUN;
                busy  <= 1'b0;
            end
        end
    end

    // Write stage: captured every edge; requests are dropped while clearing.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            w_en   <= 1'b0;
            w_addr <= '0;
            w_data <= '0;
        end else begin
            w_en   <= wren && (state == RUN);
            w_addr <= wraddress;
            w_data <= data;
        end
    end

    // Read stage: addresses frozen while rd_clk_cls is high; reset wins over the hold.
    always_ff @(posedge clock) begin
        for (int k = 0; k < NRP; k++) begin
            if (!rst_n)
                r_addr[k] <= '0;
            else if (!rd_clk_cls)
                r_addr[k] <= rdaddress[k*AW +: AW];
        end
    end

    // NOTE: the array has no reset branch; it maps onto plain RAM and the sequencer zeroes it instead.
    always_ff @(posedge clock) begin
        if (rst_n) begin
            if (state == CLR)
                mem[cnt[AW-1:0]] <= '0;
            else if (w_en && !(ZERO_R0 != 0 && w_addr == '0))
                mem[w_addr] <= w_data;
        end
    end

    // NOTE: q gets a default before the loop so no path through this block infers a latch.
    always_comb begin
        q = '0;
        for (int k = 0; k < NRP; k++) begin
            if (busy)
                q[k*DW +: DW] = '0;
            else if (ZERO_R0 != 0 && r_addr[k] == '0)
                q[k*DW +: DW] = '0;
            else if (w_en && w_addr == r_addr[k])
                q[k*DW +: DW] = w_data;
            else
                q[k*DW +: DW] = mem[r_addr[k]];
        end
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Self-checking bench for reg_file_param: a default instance and a DW=16/AW=3/NRP=4
// instance, directed vectors plus randomized traffic against an array-level model.
module tb_reg_file_param;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 clock = ~clock;

    // Instance A: defaults (DW=32, AW=5, NRP=2, ZERO_R0=1)
    logic [31:0] data_a;
    logic [4:0]  wraddress_a;
    logic        wren_a;
    logic [9:0]  rdaddress_a;
    logic        cls_a;
    logic [63:0] q_a;
    logic        busy_a;

    // Instance B: DW=16, AW=3, NRP=4
    logic [15:0] data_b;
    logic [2:0]  wraddress_b;
    logic        wren_b;
    logic [11:0] rdaddress_b;
    logic        cls_b;
    logic [63:0] q_b;
    logic        busy_b;

    reg_file_param dut_a (
        .clock(clock), .rst_n(rst_n), .data(data_a), .wraddress(wraddress_a),
        .wren(wren_a), .rdaddress(rdaddress_a), .rd_clk_cls(cls_a), .q(q_a), .busy(busy_a)
    );

    reg_file_param #(.DW(16), .AW(3), .NRP(4), .ZERO_R0(1)) dut_b (
        .clock(clock), .rst_n(rst_n), .data(data_b), .wraddress(wraddress_b),
        .wren(wren_b), .rdaddress(rdaddress_b), .rd_clk_cls(cls_b), .q(q_b), .busy(busy_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: contents as the user sees them, captured read addresses,
    // and the number of clear edges still to come.
    logic [31:0] ref_a [32];
    logic [4:0]  cap_a [2];
    int          clr_a = 32;
    logic [15:0] ref_b [8];
    logic [2:0]  cap_b [4];
    int          clr_b = 8;

    task automatic model_edge();
        if (!rst_n) begin
            clr_a = 32;
            clr_b = 8;
            for (int i = 0; i < 32; i++) ref_a[i] = '0;
            for (int i = 0; i < 8; i++)  ref_b[i] = '0;
            for (int k = 0; k < 2; k++)  cap_a[k] = '0;
            for (int k = 0; k < 4; k++)  cap_b[k] = '0;
        end else begin
            if (clr_a > 0) clr_a--;
            else if (wren_a && wraddress_a != 0) ref_a[wraddress_a] = data_a;
            if (!cls_a) for (int k = 0; k < 2; k++) cap_a[k] = rdaddress_a[k*5 +: 5];
            if (clr_b > 0) clr_b--;
            else if (wren_b && wraddress_b != 0) ref_b[wraddress_b] = data_b;
            if (!cls_b) for (int k = 0; k < 4; k++) cap_b[k] = rdaddress_b[k*3 +: 3];
        end
    endtask

    function automatic logic [31:0] exp_a(input int k);
        return (clr_a > 0 || cap_a[k] == 0) ? 32'h0 : ref_a[cap_a[k]];
    endfunction

    function automatic logic [15:0] exp_b(input int k);
        return (clr_b > 0 || cap_b[k] == 0) ? 16'h0 : ref_b[cap_b[k]];
    endfunction

    task automatic step();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic compare_all(input string tag);
        check($sformatf("%s_busy_a", tag), {63'h0, busy_a}, {63'h0, clr_a > 0});
        for (int k = 0; k < 2; k++)
            check($sformatf("%s_q_a%0d", tag, k), {32'h0, q_a[k*32 +: 32]}, {32'h0, exp_a(k)});
        check($sformatf("%s_busy_b", tag), {63'h0, busy_b}, {63'h0, clr_b > 0});
        for (int k = 0; k < 4; k++)
            check($sformatf("%s_q_b%0d", tag, k), {48'h0, q_b[k*16 +: 16]}, {48'h0, exp_b(k)});
    endtask

    // Counts cycles with busy high (sampled before each edge) until both finish, bounded.
    task automatic clear_wait(output int cyc_a, output int cyc_b);
        cyc_a = 0;
        cyc_b = 0;
        for (int i = 0; i < 100; i++) begin
            if (!busy_a && !busy_b) break;
            if (busy_a) cyc_a++;
            if (busy_b) cyc_b++;
            step();
            compare_all("clear");
        end
    endtask

    typedef struct {
        logic        wren;
        logic [4:0]  wa;
        logic [31:0] d;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic        cls;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int cyc_a, cyc_b;
        logic [15:0] vals_b [8];

        data_a = '0; wraddress_a = '0; wren_a = 1'b0; rdaddress_a = '0; cls_a = 1'b0;
        data_b = '0; wraddress_b = '0; wren_b = 1'b0; rdaddress_b = '0; cls_b = 1'b0;

        // Reset state
        rst_n = 1'b0;
        step();
        step();
        check("reset_busy_a", {63'h0, busy_a}, 64'h1);
        check("reset_q_a", q_a, 64'h0);
        check("reset_busy_b", {63'h0, busy_b}, 64'h1);
        check("reset_q_b", q_b, 64'h0);

        // Clear with wren held high on A: no write may land
        rst_n = 1'b1;
        wren_a = 1'b1; wraddress_a = 5'd9; data_a = 32'hFFFF_FFFF; rdaddress_a = {5'd9, 5'd3};
        clear_wait(cyc_a, cyc_b);
        wren_a = 1'b0;
        check("clear_len_a", 64'(cyc_a), 64'd32);
        check("clear_len_b", 64'(cyc_b), 64'd8);

        for (int i = 0; i < 32; i++) begin
            rdaddress_a = {5'(31 - i), 5'(i)};
            step();
            check($sformatf("cleared_p0_r%0d", i), {32'h0, q_a[31:0]}, 64'h0);
            check($sformatf("cleared_p1_r%0d", 31 - i), {32'h0, q_a[63:32]}, 64'h0);
        end

        // Directed vectors: bypass, r0 discard, read-address hold
        vecs[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 1'b0, 32'hDEADBEEF, 32'h0};
        vecs[1]  = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd5, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2]  = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd5, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[3]  = '{1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, 1'b0, 32'h0,        32'h0};
        vecs[4]  = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd5, 1'b0, 32'h0,        32'hDEADBEEF};
        vecs[5]  = '{1'b1, 5'd7, 32'h11111111, 5'd7, 5'd7, 1'b0, 32'h11111111, 32'h11111111};
        vecs[6]  = '{1'b0, 5'd0, 32'h0,        5'd9, 5'd9, 1'b1, 32'h11111111, 32'h11111111};
        vecs[7]  = '{1'b1, 5'd7, 32'hA5A5A5A5, 5'd9, 5'd9, 1'b1, 32'hA5A5A5A5, 32'hA5A5A5A5};
        vecs[8]  = '{1'b0, 5'd0, 32'h0,        5'd9, 5'd9, 1'b1, 32'hA5A5A5A5, 32'hA5A5A5A5};
        vecs[9]  = '{1'b0, 5'd0, 32'h0,        5'd9, 5'd5, 1'b0, 32'h0,        32'hDEADBEEF};
        vecs[10] = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd0, 1'b0, 32'hA5A5A5A5, 32'h0};

        for (int i = 0; i < 11; i++) begin
            wren_a = vecs[i].wren; wraddress_a = vecs[i].wa; data_a = vecs[i].d;
            rdaddress_a = {vecs[i].r1, vecs[i].r0}; cls_a = vecs[i].cls;
            step();
            check($sformatf("vec%0d_q0", i), {32'h0, q_a[31:0]},  {32'h0, vecs[i].e0});
            check($sformatf("vec%0d_q1", i), {32'h0, q_a[63:32]}, {32'h0, vecs[i].e1});
        end

        // Write one cycle before the address is presented: array path afterwards
        wren_a = 1'b1; wraddress_a = 5'd12; data_a = 32'hCAFEF00D; rdaddress_a = '0;
        step();
        wren_a = 1'b0; rdaddress_a = {5'd0, 5'd12};
        step();
        check("late_addr_q0", {32'h0, q_a[31:0]}, 64'hCAFEF00D);
        step();
        step();
        check("late_addr_q0_hold", {32'h0, q_a[31:0]}, 64'hCAFEF00D);

        // Reset pulse at clear step 10 restarts a full clear
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check("mid_clear_busy", {63'h0, busy_a}, 64'h1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        clear_wait(cyc_a, cyc_b);
        check("restart_len_a", 64'(cyc_a), 64'd32);
        check("restart_len_b", 64'(cyc_b), 64'd8);
        rdaddress_a = {5'd12, 5'd7};
        step();
        check("restart_zeroed", q_a, 64'h0);

        // Instance B: distinct values in r1..r7, four ports at 1,1,6,0
        for (int i = 1; i < 8; i++) begin
            vals_b[i] = 16'h1000 + 16'(i * 16'h0111);
            wren_b = 1'b1; wraddress_b = 3'(i); data_b = vals_b[i];
            step();
        end
        wren_b = 1'b0;
        rdaddress_b = {3'd0, 3'd6, 3'd1, 3'd1};
        step();
        check("b_port0", {48'h0, q_b[15:0]},  {48'h0, vals_b[1]});
        check("b_port1", {48'h0, q_b[31:16]}, {48'h0, vals_b[1]});
        check("b_port2", {48'h0, q_b[47:32]}, {48'h0, vals_b[6]});
        check("b_port3", {48'h0, q_b[63:48]}, 64'h0);

        // Randomized traffic on both instances against the model
        for (int n = 0; n < 600; n++) begin
            rst_n       = ($urandom_range(0, 149) != 0);
            wren_a      = 1'($urandom_range(0, 1));
            wraddress_a = 5'($urandom_range(0, 7));
            data_a      = $urandom;
            rdaddress_a = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            cls_a       = ($urandom_range(0, 3) == 0);
            wren_b      = 1'($urandom_range(0, 1));
            wraddress_b = 3'($urandom);
            data_b      = 16'($urandom);
            rdaddress_b = 12'($urandom);
            cls_b       = ($urandom_range(0, 3) == 0);
            step();
            compare_all("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
